// File: rtl/alu.sv
// alu: Y86 execute ALU; clock/reset_n, op1/op2/op/set_cc in, combinational result, registered SF/ZF/OF
module alu #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [3:0]       op,
  input  logic             set_cc,
  output logic [WIDTH-1:0] result,
  output logic             SF,
  output logic             ZF,
  output logic             OF
);
  localparam int M = WIDTH - 1;
  logic n_of;
  always_comb begin
    result = op == 4'd0 ? op1 + op2 :
             op == 4'd1 ? op1 - op2 :
             op == 4'd2 ? op1 & op2 :
             op == 4'd3 ? op1 ^ op2 : '0;
    n_of = op == 4'd0 ? (op1[M] == op2[M]) && (result[M] != op1[M]) :
           op == 4'd1 ? (op1[M] != op2[M]) && (result[M] != op1[M]) : 1'b0;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) {SF, ZF, OF} <= 3'b010;
    else if (set_cc) {SF, ZF, OF} <= {result[M], result == '0, n_of};
endmodule

// File: tb/tb_alu.sv
// tb_alu: randomized scoreboard bench for alu against an arithmetic reference model
module tb_alu;
  logic clock = 1'b0;
  logic reset_n = 1'b1;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic [3:0] op = '0;
  logic set_cc = 1'b0;
  logic [31:0] result;
  logic SF, ZF, OF;
  typedef struct {
    logic [31:0] r;
    logic [2:0] f;
    int id;
  } exp_t;
  exp_t q[$];
  int nvec = 0;
  int nbad = 0;
  logic [2:0] mflags = 3'b010;
  alu #(.WIDTH(32)) dut (
    .clock(clock), .reset_n(reset_n), .op1(op1), .op2(op2), .op(op),
    .set_cc(set_cc), .result(result), .SF(SF), .ZF(ZF), .OF(OF)
  );
  always #5 clock = ~clock;
  function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b, input logic [3:0] o);
    case (o)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a ^ b;
      default: return 32'd0;
    endcase
  endfunction
  function automatic logic [2:0] ref_flags(input logic [31:0] a, input logic [31:0] b, input logic [3:0] o, input logic [31:0] r);
    longint s;
    logic ov;
    s = o == 4'd0 ? longint'($signed(a)) + longint'($signed(b)) : longint'($signed(a)) - longint'($signed(b));
    ov = (o < 4'd2) && (s > 64'sd2147483647 || s < -64'sd2147483648);
    return {r[31], r == 32'd0, ov};
  endfunction
  task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [3:0] o, input logic s);
    exp_t e;
    @(negedge clock);
    op1 = a; op2 = b; op = o; set_cc = s;
    e.r = ref_result(a, b, o);
    if (s) mflags = ref_flags(a, b, o, e.r);
    e.f = mflags;
    e.id = nvec;
    nvec++;
    q.push_back(e);
  endtask
  task automatic chk_flags(input string name, input logic [2:0] want);
    nvec++;
    if ({SF, ZF, OF} !== want) begin
      nbad++;
      $display("FAIL %s: flags SF/ZF/OF got %b expected %b", name, {SF, ZF, OF}, want);
    end
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (result !== e.r) begin
          nbad++;
          $display("FAIL vec%0d result: got %h expected %h (op=%0d op1=%h op2=%h)", e.id, result, e.r, op, op1, op2);
        end
        if ({SF, ZF, OF} !== e.f) begin
          nbad++;
          $display("FAIL vec%0d flags: SF/ZF/OF got %b expected %b (op=%0d op1=%h op2=%h set_cc=%b)", e.id, {SF, ZF, OF}, e.f, op, op1, op2, set_cc);
        end
      end
    end
  end
  initial begin : driver
    logic [31:0] a, b;
    logic [3:0] o;
    #2 reset_n = 1'b0;
    #1 chk_flags("async_reset_initial", 3'b010);
    @(negedge clock);
    reset_n = 1'b1;
    mflags = 3'b010;
    apply(32'd5, 32'd3, 4'd0, 1'b0);
    apply(32'h7FFFFFFF, 32'd1, 4'd0, 1'b1);
    @(posedge clock);
    #3 reset_n = 1'b0;
    #1 chk_flags("async_reset_midcycle", 3'b010);
    op1 = 32'h80000000; op2 = 32'd1; op = 4'd0; set_cc = 1'b1;
    @(posedge clock);
    #1 chk_flags("set_cc_ignored_in_reset", 3'b010);
    @(negedge clock);
    reset_n = 1'b1;
    mflags = 3'b010;
    apply(32'd7, 32'd7, 4'd1, 1'b1);
    apply(32'h80000000, 32'd1, 4'd1, 1'b1);
    apply(32'hF0F0F0F0, 32'hFF00FF00, 4'd2, 1'b1);
    apply(32'h0BADF00D, 32'h0BADF00D, 4'd3, 1'b1);
    apply(32'h7FFFFFFF, 32'd1, 4'd0, 1'b1);
    apply(32'h00000100, 32'hFFFFFFFC, 4'd0, 1'b0);
    apply(32'h12345678, 32'd1, 4'd9, 1'b1);
    apply(32'h80000000, 32'h80000000, 4'd0, 1'b1);
    apply(32'd0, 32'h80000000, 4'd1, 1'b1);
    apply(32'hFFFFFFFF, 32'hFFFFFFFF, 4'd15, 1'b0);
    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 4))
        0: a = 32'h7FFFFFFF;
        1: b = 32'h80000000;
        2: b = a;
        default: ;
      endcase
      o = $urandom_range(0, 3) == 0 ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      apply(a, b, o, 1'($urandom_range(0, 1)));
    end
    repeat (3) @(negedge clock);
    if (q.size() != 0) begin
      nbad++;
      $display("FAIL drain: %0d expected responses left unchecked, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
